// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port round-robin sequencer in front of the single-port ram2 block.
// Port 0 is the CPU MAR/MDR path, port 1 the loader/DMA path. One transaction at a
// time: IDLE picks a winner and latches its request, ISSUE strobes the RAM, WAIT
// collects registered read data, ACK pulses the winner's ack for one cycle.
module ram_arbiter #(
  parameter int BITS    = 32,
  parameter int RAMSIZE = 512,
  parameter int ADDR    = $clog2(RAMSIZE)
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            rq0_req,
  input  logic            rq0_we,
  input  logic [ADDR-1:0] rq0_addr,
  input  logic [BITS-1:0] rq0_wdata,
  output logic            rq0_ack,
  output logic [BITS-1:0] rq0_rdata,
  input  logic            rq1_req,
  input  logic            rq1_we,
  input  logic [ADDR-1:0] rq1_addr,
  input  logic [BITS-1:0] rq1_wdata,
  output logic            rq1_ack,
  output logic [BITS-1:0] rq1_rdata,
  output logic [BITS-1:0] ram_dataIn,
  output logic            ram_read,
  output logic            ram_write,
  output logic [ADDR-1:0] ram_address,
  input  logic [BITS-1:0] ram_dataOut,
  output logic            busy,
  output logic            gnt_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t state;
  logic   last_gnt;
  logic   lat_we;

  logic            any_req;
  logic            win;
  logic            win_we;
  logic [ADDR-1:0] win_addr;
  logic [BITS-1:0] win_wdata;

  // Pick the winner: a lone requester always wins, a tie goes to the port that
  // did not win last time, which gives strict alternation under full load.
  always_comb begin
    any_req   = rq0_req | rq1_req;
    win       = (rq0_req & rq1_req) ? ~last_gnt : rq1_req;
    win_we    = win ? rq1_we    : rq0_we;
    win_addr  = win ? rq1_addr  : rq0_addr;
    win_wdata = win ? rq1_wdata : rq0_wdata;
  end

  // Sequencer FSM; every output is a register loaded on the transition into the
  // state that shows it, so the RAM sees clean strobes and acks are glitch-free.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state       <= IDLE;
      last_gnt    <= 1'b1;
      lat_we      <= 1'b0;
      gnt_id      <= 1'b0;
      busy        <= 1'b0;
      ram_read    <= 1'b0;
      ram_write   <= 1'b0;
      ram_address <= '0;
      ram_dataIn  <= '0;
      rq0_ack     <= 1'b0;
      rq1_ack     <= 1'b0;
      rq0_rdata   <= '0;
      rq1_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_id      <= win;
            last_gnt    <= win;
            lat_we      <= win_we;
            ram_address <= win_addr;
            ram_dataIn  <= win_wdata;
            ram_write   <= win_we;
            ram_read    <= ~win_we;
            busy        <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          ram_write <= 1'b0;
          ram_read  <= 1'b0;
          if (lat_we) begin
            rq0_ack <= ~gnt_id;
            rq1_ack <= gnt_id;
            state   <= ACK;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (gnt_id) begin
            rq1_rdata <= ram_dataOut;
          end else begin
            rq0_rdata <= ram_dataOut;
          end
          rq0_ack <= ~gnt_id;
          rq1_ack <= gnt_id;
          state   <= ACK;
        end
        ACK: begin
          rq0_ack <= 1'b0;
          rq1_ack <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed table, hand-written corner sequences and a randomized
// phase checked against a transaction-level model of the arbiter.
module tb_ram_arbiter;

  localparam int BITS    = 32;
  localparam int RAMSIZE = 512;
  localparam int ADDR    = 9;

  logic            clk = 1'b0;
  logic            clr_n = 1'b0;
  logic            rq0_req = 1'b0, rq0_we = 1'b0;
  logic [ADDR-1:0] rq0_addr = '0;
  logic [BITS-1:0] rq0_wdata = '0;
  logic            rq0_ack;
  logic [BITS-1:0] rq0_rdata;
  logic            rq1_req = 1'b0, rq1_we = 1'b0;
  logic [ADDR-1:0] rq1_addr = '0;
  logic [BITS-1:0] rq1_wdata = '0;
  logic            rq1_ack;
  logic [BITS-1:0] rq1_rdata;
  logic [BITS-1:0] ram_dataIn;
  logic            ram_read, ram_write;
  logic [ADDR-1:0] ram_address;
  logic [BITS-1:0] ram_dataOut;
  logic            busy, gnt_id;

  always #10 clk = ~clk;

  ram_arbiter #(.BITS(BITS), .RAMSIZE(RAMSIZE), .ADDR(ADDR)) dut (
    .clk(clk), .clr_n(clr_n),
    .rq0_req(rq0_req), .rq0_we(rq0_we), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
    .rq0_ack(rq0_ack), .rq0_rdata(rq0_rdata),
    .rq1_req(rq1_req), .rq1_we(rq1_we), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
    .rq1_ack(rq1_ack), .rq1_rdata(rq1_rdata),
    .ram_dataIn(ram_dataIn), .ram_read(ram_read), .ram_write(ram_write),
    .ram_address(ram_address), .ram_dataOut(ram_dataOut),
    .busy(busy), .gnt_id(gnt_id)
  );

  // Stand-in for ram2: synchronous write, one-cycle registered read.
  logic [BITS-1:0] mem [RAMSIZE];
  always @(posedge clk) begin
    if (ram_write) mem[ram_address] <= ram_dataIn;
    if (ram_read) ram_dataOut <= mem[ram_address];
  end

  int errors = 0;
  int checks = 0;
  logic [BITS-1:0] exp_rd [2];

  typedef struct {
    int              port;
    logic            we;
    logic [ADDR-1:0] addr;
    logic [BITS-1:0] wdata;
    logic [BITS-1:0] exp_rdata;
  } vec_t;
  vec_t tbl [8];

  task automatic checkOutput(input string name, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input int p, input logic r, input logic w,
                         input logic [ADDR-1:0] a, input logic [BITS-1:0] d);
    if (p == 0) begin
      rq0_req = r; rq0_we = w; rq0_addr = a; rq0_wdata = d;
    end else begin
      rq1_req = r; rq1_we = w; rq1_addr = a; rq1_wdata = d;
    end
  endtask

  function automatic logic get_ack(input int p);
    return (p == 0) ? rq0_ack : rq1_ack;
  endfunction

  function automatic logic [BITS-1:0] get_rdata(input int p);
    return (p == 0) ? rq0_rdata : rq1_rdata;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    clr_n = 1'b0;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    clr_n = 1'b1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  // One isolated transaction from an idle arbiter, with latency and data checks.
  task automatic applyStimulus(input int p, input logic we, input logic [ADDR-1:0] addr,
                               input logic [BITS-1:0] wdata, input logic [BITS-1:0] exp_rdata,
                               input string tag);
    int  cnt;
    bit  done;
    @(negedge clk);
    checkOutput({tag, " idle ack0"}, rq0_ack, 0);
    checkOutput({tag, " idle ack1"}, rq1_ack, 0);
    checkOutput({tag, " idle busy"}, busy, 0);
    set_req(p, 1'b1, we, addr, wdata);
    cnt  = 0;
    done = 0;
    while (!done && cnt < 8) begin
      @(negedge clk);
      cnt++;
      checkOutput({tag, " other ack"}, get_ack(1 - p), 0);
      if (cnt == 1) begin
        checkOutput({tag, " issue write"}, ram_write, we);
        checkOutput({tag, " issue read"}, ram_read, !we);
        checkOutput({tag, " issue addr"}, ram_address, addr);
        checkOutput({tag, " issue dataIn"}, ram_dataIn, wdata);
        checkOutput({tag, " issue gnt"}, gnt_id, p[0]);
        checkOutput({tag, " issue busy"}, busy, 1);
      end
      if (get_ack(p)) begin
        done = 1;
        checkOutput({tag, " latency"}, cnt, we ? 2 : 3);
        if (!we) exp_rd[p] = exp_rdata;
        checkOutput({tag, " rdata own"}, get_rdata(p), exp_rd[p]);
        checkOutput({tag, " rdata other"}, get_rdata(1 - p), exp_rd[1 - p]);
        set_req(p, 1'b0, 1'b0, '0, '0);
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: got no ack expected ack within 8 cycles", tag);
      set_req(p, 1'b0, 1'b0, '0, '0);
    end
  endtask

  // Both ports requesting continuously: port 0 writes a sequence, port 1 re-reads one word.
  task automatic runStream(input int n_each, input logic [ADDR-1:0] base0, input logic [BITS-1:0] dbase0,
                           input logic [ADDR-1:0] addr1, input logic [BITS-1:0] exp1,
                           input int first, input string tag);
    int i0, i1, grants, cyc, exp_port;
    i0 = 0; i1 = 0; grants = 0; exp_port = first;
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, base0, dbase0);
    set_req(1, 1'b1, 1'b0, addr1, '0);
    cyc = 0;
    while (cyc < 12 * n_each && grants < 2 * n_each) begin
      @(negedge clk);
      cyc++;
      if (rq0_ack || rq1_ack) begin
        checkOutput($sformatf("%s both acks g%0d", tag, grants), rq0_ack & rq1_ack, 0);
        checkOutput($sformatf("%s grant port g%0d", tag, grants), rq1_ack, exp_port[0]);
        if (rq0_ack) begin
          i0++;
          checkOutput($sformatf("%s p1 rdata held g%0d", tag, grants), rq1_rdata, exp_rd[1]);
          if (i0 < n_each) set_req(0, 1'b1, 1'b1, ADDR'(base0 + i0), BITS'(dbase0 + i0));
          else set_req(0, 1'b0, 1'b0, '0, '0);
        end
        if (rq1_ack) begin
          i1++;
          exp_rd[1] = exp1;
          checkOutput($sformatf("%s p1 rdata g%0d", tag, grants), rq1_rdata, exp1);
          checkOutput($sformatf("%s p0 rdata held g%0d", tag, grants), rq0_rdata, exp_rd[0]);
          if (i1 >= n_each) set_req(1, 1'b0, 1'b0, '0, '0);
        end
        grants++;
        exp_port = 1 - exp_port;
      end
    end
    if (grants < 2 * n_each) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: got %0d grants expected %0d", tag, grants, 2 * n_each);
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
  endtask

  // Transaction-level reference model state for the random phase.
  bit              in_txn;
  int              t_start, t_ack, t_free, t_port;
  logic            t_we, last_g, exp_gnt;
  logic [ADDR-1:0] t_addr, exp_addr;
  logic [BITS-1:0] t_data, exp_din;
  logic [BITS-1:0] shadow [16];
  bit              act [2];
  logic            d_we [2];
  logic [ADDR-1:0] d_addr [2];
  logic [BITS-1:0] d_data [2];

  initial begin
    tbl[0] = '{0, 1'b1, 9'h003, 32'h0000_0005, 32'h0};
    tbl[1] = '{1, 1'b0, 9'h003, 32'h1111_1111, 32'h0000_0005};
    tbl[2] = '{1, 1'b1, 9'h007, 32'hDEAD_BEEF, 32'h0};
    tbl[3] = '{0, 1'b0, 9'h007, 32'h0, 32'hDEAD_BEEF};
    tbl[4] = '{0, 1'b1, 9'h1FF, 32'h1234_5678, 32'h0};
    tbl[5] = '{1, 1'b0, 9'h1FF, 32'h0, 32'h1234_5678};
    tbl[6] = '{0, 1'b1, 9'h000, 32'hFFFF_FFFF, 32'h0};
    tbl[7] = '{0, 1'b0, 9'h000, 32'h2222_2222, 32'hFFFF_FFFF};
    exp_rd[0] = '0;
    exp_rd[1] = '0;

    // Reset values while clr_n is held low, then quiet IDLE after release.
    repeat (2) @(negedge clk);
    checkOutput("reset ack0", rq0_ack, 0);
    checkOutput("reset ack1", rq1_ack, 0);
    checkOutput("reset rdata0", rq0_rdata, 0);
    checkOutput("reset rdata1", rq1_rdata, 0);
    checkOutput("reset read", ram_read, 0);
    checkOutput("reset write", ram_write, 0);
    checkOutput("reset addr", ram_address, 0);
    checkOutput("reset dataIn", ram_dataIn, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset gnt", gnt_id, 0);
    clr_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("idle busy", busy, 0);
      checkOutput("idle strobes", {ram_read, ram_write}, 0);
    end

    // Directed single transactions.
    for (int i = 0; i < 8; i++)
      applyStimulus(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata,
                    $sformatf("vec%0d", i));
    checkOutput("ram[3]", mem[3], 32'h5);
    checkOutput("ram[7]", mem[7], 32'hDEAD_BEEF);
    checkOutput("ram[1ff]", mem[9'h1FF], 32'h1234_5678);

    // Simultaneous requests after reset: grants 0,1,0,1.
    do_reset();
    runStream(2, 9'h020, 32'hA0, 9'h003, 32'h5, 0, "tie");
    checkOutput("ram[20]", mem[9'h020], 32'hA0);
    checkOutput("ram[21]", mem[9'h021], 32'hA1);

    // Back-to-back writes from port 0 interleaved with port 1 reads of word 0.
    runStream(16, 9'h000, 32'h0, 9'h000, 32'h0, 0, "stream");
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("stream ram[%0d]", i), mem[i], BITS'(i));

    // Reset in the WAIT state of a read.
    applyStimulus(1, 1'b0, 9'h007, 32'h0, 32'h7, "pre-abort");
    @(negedge clk);
    set_req(1, 1'b1, 1'b0, 9'h009, '0);
    @(negedge clk);
    checkOutput("abort issue read", ram_read, 1);
    @(negedge clk);
    checkOutput("abort wait busy", busy, 1);
    checkOutput("abort wait strobe", ram_read, 0);
    clr_n = 1'b0;
    #1;
    checkOutput("abort busy", busy, 0);
    checkOutput("abort ack1", rq1_ack, 0);
    checkOutput("abort rdata1", rq1_rdata, 0);
    checkOutput("abort gnt", gnt_id, 0);
    checkOutput("abort addr", ram_address, 0);
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    @(negedge clk);
    clr_n = 1'b1;
    set_req(1, 1'b0, 1'b0, '0, '0);
    repeat (4) begin
      @(negedge clk);
      checkOutput("abort no ack", rq1_ack, 0);
      checkOutput("abort idle busy", busy, 0);
    end
    applyStimulus(1, 1'b0, 9'h005, 32'h0, 32'h5, "post-abort");

    // Randomized traffic against the transaction-level model.
    do_reset();
    in_txn = 0; t_free = 0; last_g = 1'b1; exp_gnt = 1'b0;
    exp_addr = '0; exp_din = '0;
    t_start = 0; t_ack = 0; t_port = 0; t_we = 0; t_addr = '0; t_data = '0;
    for (int i = 0; i < 16; i++) shadow[i] = BITS'(i);
    for (int p = 0; p < 2; p++) begin
      act[p] = 0; d_we[p] = 0; d_addr[p] = '0; d_data[p] = '0;
    end
    for (int k = 0; k < 400; k++) begin
      bit issue;
      if (k > 0) @(negedge clk);
      issue = in_txn && (k == t_start + 1);
      if (issue) begin
        exp_gnt  = t_port[0];
        exp_addr = t_addr;
        exp_din  = t_data;
      end
      if (in_txn && k == t_ack && !t_we) exp_rd[t_port] = shadow[t_addr[3:0]];
      checkOutput($sformatf("rnd ack0 c%0d", k), rq0_ack, in_txn && k == t_ack && t_port == 0);
      checkOutput($sformatf("rnd ack1 c%0d", k), rq1_ack, in_txn && k == t_ack && t_port == 1);
      checkOutput($sformatf("rnd busy c%0d", k), busy, in_txn && k > t_start && k <= t_ack);
      checkOutput($sformatf("rnd write c%0d", k), ram_write, issue && t_we);
      checkOutput($sformatf("rnd read c%0d", k), ram_read, issue && !t_we);
      checkOutput($sformatf("rnd gnt c%0d", k), gnt_id, exp_gnt);
      checkOutput($sformatf("rnd addr c%0d", k), ram_address, exp_addr);
      checkOutput($sformatf("rnd dataIn c%0d", k), ram_dataIn, exp_din);
      checkOutput($sformatf("rnd rdata0 c%0d", k), rq0_rdata, exp_rd[0]);
      checkOutput($sformatf("rnd rdata1 c%0d", k), rq1_rdata, exp_rd[1]);
      if (in_txn && k == t_ack) begin
        if (t_we) shadow[t_addr[3:0]] = t_data;
        in_txn = 0;
      end
      for (int p = 0; p < 2; p++) begin
        if (act[p] && get_ack(p)) act[p] = 0;
        if (!act[p] && $urandom_range(0, 2) == 0) begin
          act[p]    = 1;
          d_we[p]   = 1'($urandom_range(0, 1));
          d_addr[p] = ADDR'($urandom_range(0, 15));
          d_data[p] = BITS'($urandom);
        end
        set_req(p, act[p], d_we[p], d_addr[p], d_data[p]);
      end
      if (!in_txn && k >= t_free && (act[0] || act[1])) begin
        t_port  = (act[0] && act[1]) ? (last_g ? 0 : 1) : (act[1] ? 1 : 0);
        last_g  = t_port[0];
        t_we    = d_we[t_port];
        t_addr  = d_addr[t_port];
        t_data  = d_data[t_port];
        t_start = k;
        t_ack   = k + (t_we ? 2 : 3);
        t_free  = t_ack + 1;
        in_txn  = 1;
      end
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    repeat (6) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
